// File: rtl/note_detector.sv
// note_detector: measures a square-wave period in clk_in cycles (ports: clk_in, rst, wave_in -> period, period_valid, silent)
module note_detector #(
  parameter int TIMEOUT = 600000,
  parameter int MIN_PERIOD = 16,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         wave_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         silent
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;
  localparam logic [W-1:0] TO = W'(TIMEOUT);
  localparam logic [W-1:0] MP = W'(MIN_PERIOD);
  state_t r_state;
  logic r_s1, r_s2, r_p;
  logic [W-1:0] r_cnt;
  logic w_rise, w_sat, w_long;
  assign w_rise = r_s2 & ~r_p;
  assign w_sat  = r_cnt == TO;
  assign w_long = r_cnt >= MP;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_p          <= 1'b0;
      r_cnt        <= '0;
      r_state      <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
    end else begin
      r_s1         <= wave_in;
      r_s2         <= r_s1;
      r_p          <= r_s2;
      period_valid <= 1'b0;
      r_cnt        <= w_sat ? r_cnt : r_cnt + W'(1);
      if (r_state == IDLE) begin
        if (w_rise) begin
          r_state <= ARMED;
          r_cnt   <= W'(1);
          silent  <= 1'b0;
        end
      end else if (w_rise && w_long) begin
        // an edge landing on the saturated count still counts as a TIMEOUT-long period
        period       <= r_cnt;
        period_valid <= 1'b1;
        r_state      <= LOCKED;
        r_cnt        <= W'(1);
      end else if (!w_rise && w_sat) begin
        r_state <= IDLE;
        silent  <= 1'b1;
        period  <= '0;
      end
    end
  end
endmodule
